// File: rtl/spm_stream_mult.sv
// Handshaked serial-parallel multiplier: x*y streamed out LSB-first through a
// WIDTH-cell carry-save chain, unsigned or two's-complement per operation.

// One carry-save cell: full adder of the partial product with the stored sum
// and carry bits of this lane. 'inv' complements the partial product. The top
// lane uses it in signed mode to turn the negative-weight x MSB term into a
// non-negative one.
module spm_csa_cell (
    input  logic x_bit,
    input  logic b,
    input  logic inv,
    input  logic s_in,
    input  logic c_in,
    output logic sum,
    output logic carry
);
    logic pp;

    assign pp    = (x_bit & b) ^ inv;
    assign sum   = pp ^ s_in ^ c_in;
    assign carry = (pp & s_in) | (pp & c_in) | (s_in & c_in);
endmodule

module spm_stream_mult #(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             tc,
    input  logic             abort,
    output logic             p,
    output logic             p_valid,
    output logic             p_last,
    output logic             busy
);
    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] K_LAST = CW'(2 * WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    // Latched operation: multiplicand, remaining multiplier bits (y shifted
    // right with sign fill, so bit 0 is always the next bit to feed), mode.
    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y_sh;
        logic             tc;
    } op_t;

    state_t           state, state_nxt;
    op_t              op_q, op_nxt;
    logic [CW-1:0]    k_q, k_nxt;
    logic [WIDTH-1:0] s_q, c_q, s_nxt, c_nxt;
    logic             rdy_q, rdy_nxt;
    logic             p_nxt, pv_nxt, pl_nxt;
    logic             adv;

    logic             tc_in, accept, b, tc_op;
    logic [WIDTH-1:0] x_op, s_cur, c_cur, sum, carry;

    assign tc_in       = SIGNED_EN ? tc : 1'b0;
    assign busy        = (state == RUN);
    // Abort during an operation also vetoes a restart in its last cycle.
    assign start_ready = rdy_q & ~(busy & abort);
    assign accept      = start_valid & start_ready;

    // Product bit k is registered on the edge of accept + k, so bit 0 is
    // computed straight from the port operands on the accept edge, with the
    // csa state taken as cleared. In signed mode the top lane's carry is
    // seeded with 1 on that step: summing the complemented MSB partial
    // products over all 2*WIDTH steps leaves an offset of -2^(WIDTH-1)
    // modulo 2^(2*WIDTH), and this seed cancels it.
    assign x_op  = accept ? x : op_q.x;
    assign tc_op = accept ? tc_in : op_q.tc;
    assign b     = accept ? y[0] : op_q.y_sh[0];
    assign s_cur = accept ? '0 : s_q;
    assign c_cur = accept ? {tc_in, {(WIDTH-1){1'b0}}} : c_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        spm_csa_cell u_cell (
            .x_bit (x_op[i]),
            .b     (b),
            .inv   ((i == WIDTH - 1) ? tc_op : 1'b0),
            .s_in  (s_cur[i]),
            .c_in  (c_cur[i]),
            .sum   (sum[i]),
            .carry (carry[i])
        );
    end

    // Next-state, operand latch, csa update and output bit selection.
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        k_nxt     = k_q;
        s_nxt     = s_q;
        c_nxt     = c_q;
        p_nxt     = 1'b0;
        pv_nxt    = 1'b0;
        pl_nxt    = 1'b0;
        adv       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt   = RUN;
                    k_nxt       = '0;
                    op_nxt.x    = x;
                    op_nxt.y_sh = {tc_in & y[WIDTH-1], y[WIDTH-1:1]};
                    op_nxt.tc   = tc_in;
                    adv         = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                    k_nxt     = '0;
                    s_nxt     = '0;
                    c_nxt     = '0;
                end else if (accept) begin
                    // Back-to-back restart from the last-bit cycle.
                    k_nxt       = '0;
                    op_nxt.x    = x;
                    op_nxt.y_sh = {tc_in & y[WIDTH-1], y[WIDTH-1:1]};
                    op_nxt.tc   = tc_in;
                    adv         = 1'b1;
                end else if (k_q == K_LAST) begin
                    state_nxt = IDLE;
                    k_nxt     = '0;
                    s_nxt     = '0;
                    c_nxt     = '0;
                end else begin
                    k_nxt       = k_q + CW'(1);
                    op_nxt.y_sh = {op_q.tc & op_q.y_sh[WIDTH-1], op_q.y_sh[WIDTH-1:1]};
                    pl_nxt      = (k_nxt == K_LAST);
                    adv         = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Shift the csa frame right by one lane and emit lane 0's sum.
        if (adv) begin
            s_nxt  = {1'b0, sum[WIDTH-1:1]};
            c_nxt  = carry;
            p_nxt  = sum[0];
            pv_nxt = 1'b1;
        end
        rdy_nxt = (state_nxt == IDLE) || (k_nxt == K_LAST);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            op_q    <= '0;
            k_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            rdy_q   <= 1'b0;
            p       <= 1'b0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            op_q    <= op_nxt;
            k_q     <= k_nxt;
            s_q     <= s_nxt;
            c_q     <= c_nxt;
            rdy_q   <= rdy_nxt;
            p       <= p_nxt;
            p_valid <= pv_nxt;
            p_last  <= pl_nxt;
        end
    end
endmodule

// File: tb/tb_spm_stream_mult.sv
// Bench for spm_stream_mult, WIDTH=8: a signed-capable and an unsigned-only
// instance share stimulus; a queue model of the product bit stream checks both.
module tb_spm_stream_mult;
    localparam int W = 8;

    logic         clk, rst;
    logic         start_valid, tc, abort;
    logic [W-1:0] x, y;
    logic         rdy_s, p_s, pv_s, pl_s, busy_s;
    logic         rdy_u, p_u, pv_u, pl_u, busy_u;

    int checks = 0;
    int errs   = 0;

    // Model: pending product bits {signed-instance bit, unsigned-instance bit}
    logic [1:0]    qb[$];
    logic [31:0]   qw[$];
    logic          shown = 1'b0;
    logic          rdy_en = 1'b0;
    logic [15:0]   ws, wu;
    int            bi = 0;

    spm_stream_mult #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy_s),
        .x(x), .y(y), .tc(tc), .abort(abort),
        .p(p_s), .p_valid(pv_s), .p_last(pl_s), .busy(busy_s)
    );

    spm_stream_mult #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy_u),
        .x(x), .y(y), .tc(tc), .abort(abort),
        .p(p_u), .p_valid(pv_u), .p_last(pl_u), .busy(busy_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        qb.delete();
        qw.delete();
        bi = 0;
    endtask

    // Queue the expected stream for an accepted operation.
    task automatic push(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic tv);
        int xu, yu, xs, ys;
        logic [15:0] ps, pu;
        xu = int'(xv);
        yu = int'(yv);
        xs = xu;
        ys = yu;
        if (tv) begin
            if (xs >= 128) xs -= 256;
            if (ys >= 128) ys -= 256;
        end
        ps = 16'(xs * ys);
        pu = 16'(xu * yu);
        for (int k = 0; k < 16; k++) qb.push_back({ps[k], pu[k]});
        qw.push_back({ps, pu});
    endtask

    // Compare this cycle's outputs with the head of the model stream.
    task automatic sample();
        logic [1:0] e;
        logic       last;
        logic [7:0] eo;
        if (qb.size() > 0) begin
            e     = qb.pop_front();
            last  = (qb.size() == 0);
            shown = 1'b1;
            eo    = {1'b1, e[1], last, 1'b1, 1'b1, e[0], last, 1'b1};
        end else begin
            last  = 1'b0;
            shown = 1'b0;
            eo    = 8'h00;
        end
        chk("out", {pv_s, p_s, pl_s, busy_s, pv_u, p_u, pl_u, busy_u}, eo);
        if (shown) begin
            ws[bi] = p_s;
            wu[bi] = p_u;
            bi++;
            if (last) begin
                chk("prod", {ws, wu}, qw.pop_front());
                bi = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) rdy_en = 1'b1;
        @(negedge clk);
        sample();
    endtask

    // One cycle: apply inputs at the falling edge, check readiness, update model.
    task automatic drive(input logic sv, input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic tv, input logic ab, output logic acc);
        logic er;
        start_valid = sv;
        x = xv;
        y = yv;
        tc = tv;
        abort = ab;
        #1;
        er = rdy_en && (qb.size() == 0) && !(shown && ab);
        chk("rdy", {rdy_s, rdy_u}, {er, er});
        acc = sv && er;
        if (ab && shown) clear_model();
        if (acc) push(xv, yv, tv);
        tick();
    endtask

    task automatic op(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic tv, input int idle);
        logic a, d;
        a = 1'b0;
        for (int i = 0; i < 40 && !a; i++) drive(1'b1, xv, yv, tv, 1'b0, a);
        chk("accept", {63'b0, a}, 64'd1);
        for (int i = 0; i < idle; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, d);
    endtask

    // Reset asserted between clock edges; outputs must drop without an edge.
    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        chk("rst_async", {rdy_s, pv_s, p_s, pl_s, busy_s, rdy_u, pv_u, p_u, pl_u, busy_u}, 64'd0);
        clear_model();
        shown  = 1'b0;
        rdy_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    // Directed scenarios followed by a random phase.
    initial begin
        logic d;
        logic [W-1:0] rx, ry;
        rst = 1'b0;
        start_valid = 1'b0;
        x = '0;
        y = '0;
        tc = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_state", {rdy_s, pv_s, p_s, pl_s, busy_s, rdy_u, pv_u, p_u, pl_u, busy_u}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, d);

        op(8'hFF, 8'hFF, 1'b0, 16);
        op(8'h80, 8'h7F, 1'b1, 16);
        op(8'h80, 8'h7F, 1'b0, 16);
        // back-to-back: second request waits through the first op
        op(8'hFF, 8'hFF, 1'b0, 0);
        op(8'h03, 8'h05, 1'b0, 16);
        // abort at k=5, then a clean op
        op(8'h5A, 8'h33, 1'b1, 5);
        drive(1'b0, '0, '0, 1'b0, 1'b1, d);
        op(8'h02, 8'h02, 1'b0, 16);
        // abort while idle is harmless
        drive(1'b0, '0, '0, 1'b0, 1'b1, d);
        // async reset at k=9
        op(8'h77, 8'h99, 1'b1, 9);
        reset_mid();
        op(8'h01, 8'h01, 1'b0, 16);
        // signed corners, unsigned-only build sees the same as unsigned
        op(8'hFF, 8'hFF, 1'b1, 16);
        op(8'h00, 8'hA5, 1'b1, 16);
        op(8'h7F, 8'h80, 1'b1, 16);

        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 4))
                0: rx = 8'h80;
                1: rx = 8'hFF;
                default: rx = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: ry = 8'h7F;
                1: ry = 8'h00;
                default: ry = 8'($urandom);
            endcase
            drive($urandom_range(0, 2) != 0, rx, ry, 1'($urandom), $urandom_range(0, 40) == 0, d);
        end
        for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, d);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule

// File: doc/spm_stream_mult.md
Name: spm_stream_mult

Overview:
Parametrised, handshaked successor to the spm carry-save serial-parallel multiplier cell array.
- Accepts parallel operands x and y through a valid/ready start handshake.
- Internally serialises y LSB-first into a WIDTH-cell carry-save (csa) chain, with signed or unsigned mode selectable per operation.
- Streams the 2*WIDTH-bit product out LSB-first, one bit per cycle, with valid and last markers.
- Supports back-to-back operations with no gap cycle, and synchronous abort.

Parameters:
- WIDTH, 32, operand width in bits (>=2); product is 2*WIDTH bits.
- SIGNED_EN, 1, when 0 the tc input is ignored and all operations are unsigned.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- start_valid  in  1  operand pair offered
- start_ready  out  1  block can accept operands this cycle
- x  in  WIDTH  parallel multiplicand, sampled on accept
- y  in  WIDTH  multiplier, sampled on accept, serialised internally
- tc  in  1  two's-complement mode for this operation, sampled on accept
- abort  in  1  synchronous cancel of operation in flight
- p  out  1  serial product bit
- p_valid  out  1  p carries a product bit
- p_last  out  1  p is product bit 2*WIDTH-1
- busy  out  1  operation in flight (state RUN)

Behaviour:
- Reset (rst low, async):
  - state=IDLE; csa sum/carry registers, y shift register and bit counter all cleared.
  - p, p_valid, p_last, busy = 0; start_ready = 0.
- start_ready is a registered output. It rises on the first clk edge after rst deasserts.
- Accept occurs when start_valid && start_ready at a rising edge (edge E0).
  - x, y and tc are latched; tc is forced to 0 when SIGNED_EN=0.
  - counter cleared; state moves to RUN.
- start_ready is high in two cases, and low otherwise:
  - in IDLE;
  - in the RUN cycle in which p_last is high, when abort is low.
- FSM states:
  - IDLE: wait for accept.
  - RUN: counter k counts 0..2*WIDTH-1; transitions to IDLE after the p_last cycle, or to RUN again (restarted, counter 0) if an accept occurs in that cycle.
- Serial feed during RUN: cycle k feeds y[k] for k<WIDTH. For k>=WIDTH it feeds y[WIDTH-1] if tc, else 0 (sign extension).
- Signed x: the top csa cell handles x[WIDTH-1] with two's-complement correction. Implementation method is free, but the result must be exact.
- Output timing:
  - p, p_valid and p_last are registered.
  - In the cycle following edge E0+k (k=0..2*WIDTH-1): p_valid=1 and p = P[k], where P = x*y as a 2*WIDTH-bit value (signed product if tc, else unsigned).
  - p_last=1 only with P[2*WIDTH-1].
  - Latency: first bit appears 1 cycle after accept; total 2*WIDTH valid cycles. No backpressure on p.
- Back-to-back: an accept in the p_last cycle makes P'[0] appear in the immediately following cycle. p_valid stays high with no bubble, and the csa state is cleared for the new operation.
- Abort:
  - abort high during RUN: on the next edge, state goes to IDLE, csa and counter are cleared, and p_valid/p_last go to 0.
  - abort in IDLE has no effect.
  - abort blocks acceptance in the same cycle (start_ready gated).
- busy=1 exactly while state=RUN.
- start_valid while start_ready=0 is ignored; operands may change freely.
- Async reset mid-RUN: outputs go to 0 immediately, with no partial bits after release.

Test Plan:
1. WIDTH=8, tc=0, x=0xFF, y=0xFF -> p_valid for 16 cycles starting 1 cycle after accept; bits LSB-first form 0xFE01; p_last only on the 16th bit.
2. WIDTH=8, tc=1, x=0x80 (-128), y=0x7F (127) -> 0xC080 (-16256). Same operands with tc=0 -> 0x3F80 (16256).
3. Back-to-back: second request (x=3, y=5, tc=0) held valid and accepted in the p_last cycle of op 1 -> P'=0x000F bits follow with no gap, p_valid continuous for 32 cycles.
4. abort asserted at RUN cycle k=5 -> p_valid=0 and start_ready=1 next cycle. Then x=2, y=2 -> 0x0004 with no residue from the aborted op.
5. rst pulled low mid-RUN (k=9), asynchronously -> p, p_valid, p_last, busy drop without a clock. start_ready stays 0 until the first edge after release. Next op x=0x01, y=0x01 -> 0x0001.
6. Corners, tc=1: x=0xFF, y=0xFF -> 0x0001; x=0, y=0xA5 -> all bits 0. SIGNED_EN=0 build with tc=1, x=0xFF, y=0xFF -> 0xFE01.
